hazard_scoreboard: RTL and testbench

//  Parametrised in-order scoreboard that replaces fixed per-stage rd/rs compare chains in decode.

---
 rtl/hazard_scoreboard.sv | 125 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-order issue/retire scoreboard raising decode RAW stalls
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int DEPTH    = 4,
    parameter int NUM_SRC  = 2,
    parameter int CNT_W    = $clog2(DEPTH + 1),
    parameter int ZERO_REG = 1
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      issue_valid_i,
    input  logic                      issue_we_i,
    input  logic [ADDR_W-1:0]         issue_rd_i,
    input  logic [NUM_SRC-1:0]        src_valid_i,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr_i,
    output logic                      issue_accept_o,
    output logic                      stall_o,
    output logic [NUM_SRC-1:0]        hazard_o,
    input  logic                      wb_valid_i,
    input  logic [ADDR_W-1:0]         wb_rd_i,
    input  logic                      flush_i,
    input  logic [CNT_W-1:0]          flush_n_i,
    output logic [CNT_W-1:0]          occupancy_o,
    output logic                      empty_o,
    output logic                      full_o,
    output logic                      err_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic              we_q [DEPTH];
    logic [ADDR_W-1:0] rd_q [DEPTH];
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q;
    logic              err_q;

    logic [ADDR_W-1:0] src_a [NUM_SRC];
    logic [DEPTH-1:0]  ent_live;
    logic              retire, wb_err;
    logic [CNT_W-1:0]  cnt_ret, drop;
    logic [PTR_W-1:0]  tail_flush;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_sub(input logic [PTR_W-1:0] p,
                                                 input logic [CNT_W-1:0] n);
        logic [CNT_W:0] pe, ne, r;
        pe = (CNT_W + 1)'(p);
        ne = (CNT_W + 1)'(n);
        if (pe >= ne) r = pe - ne;
        else          r = pe + (CNT_W + 1)'(DEPTH) - ne;
        return PTR_W'(r);
    endfunction

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        assign src_a[k] = src_addr_i[k*ADDR_W +: ADDR_W];
    end

    always_comb begin
        int off;
        off      = 0;
        ent_live = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = (i >= int'(head_q)) ? i - int'(head_q) : i + DEPTH - int'(head_q);
            ent_live[i] = (off < int'(count_q));
        end
    end

    // The retiring head still counts: the regfile write lands one cycle later.
    always_comb begin
        hazard_o = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (src_valid_i[k] && ent_live[i] && we_q[i] && (rd_q[i] == src_a[k])
                    && !((ZERO_REG != 0) && (src_a[k] == '0)))
                    hazard_o[k] = 1'b1;
            end
        end
    end

    assign occupancy_o    = count_q;
    assign empty_o        = (count_q == '0);
    assign full_o         = (count_q == CNT_W'(DEPTH));
    assign err_o          = err_q;
    assign stall_o        = (|hazard_o) | full_o;
    assign issue_accept_o = issue_valid_i & ~stall_o & ~flush_i;

    // Retire is applied before flush, so flush clamps against post-retire occupancy.
    assign retire     = wb_valid_i && !empty_o;
    assign wb_err     = wb_valid_i && (empty_o || (we_q[head_q] && (rd_q[head_q] != wb_rd_i)));
    assign cnt_ret    = count_q - CNT_W'(retire);
    assign drop       = flush_i ? ((flush_n_i < cnt_ret) ? flush_n_i : cnt_ret) : '0;
    assign tail_flush = ptr_sub(tail_q, drop);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                we_q[i] <= 1'b0;
                rd_q[i] <= '0;
            end
        end else begin
            if (retire) head_q <= ptr_inc(head_q);
            if (wb_err) err_q  <= 1'b1;
            if (flush_i) begin
                tail_q  <= tail_flush;
                count_q <= cnt_ret - drop;
            end else if (issue_accept_o) begin
                we_q[tail_q] <= issue_we_i;
                rd_q[tail_q] <= issue_rd_i;
                tail_q       <= ptr_inc(tail_q);
                count_q      <= cnt_ret + CNT_W'(1);
            end else begin
                count_q <= cnt_ret;
            end
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed and reference-model checks for hazard_scoreboard
module tb_hazard_scoreboard;
    logic       clk = 1'b0;
    logic       rstn;
    logic       issue_valid, issue_we;
    logic [4:0] issue_rd;
    logic [1:0] src_valid;
    logic [9:0] src_addr;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       flush;
    logic [2:0] flush_n;

    logic       acc, stall, empty, full, err;
    logic [1:0] haz;
    logic [2:0] occ;
    logic       acc_z, stall_z, empty_z, full_z, err_z;
    logic [1:0] haz_z;
    logic [2:0] occ_z;

    int checks = 0;
    int failures = 0;

    typedef struct {logic we; logic [4:0] rd;} ent_t;
    ent_t q[$];

    always #5 clk = ~clk;

    hazard_scoreboard #(.ZERO_REG(1)) dut (
        .clk_i(clk), .rstn_i(rstn), .issue_valid_i(issue_valid), .issue_we_i(issue_we),
        .issue_rd_i(issue_rd), .src_valid_i(src_valid), .src_addr_i(src_addr),
        .issue_accept_o(acc), .stall_o(stall), .hazard_o(haz), .wb_valid_i(wb_valid),
        .wb_rd_i(wb_rd), .flush_i(flush), .flush_n_i(flush_n), .occupancy_o(occ),
        .empty_o(empty), .full_o(full), .err_o(err));

    hazard_scoreboard #(.ZERO_REG(0)) dut_z0 (
        .clk_i(clk), .rstn_i(rstn), .issue_valid_i(issue_valid), .issue_we_i(issue_we),
        .issue_rd_i(issue_rd), .src_valid_i(src_valid), .src_addr_i(src_addr),
        .issue_accept_o(acc_z), .stall_o(stall_z), .hazard_o(haz_z), .wb_valid_i(wb_valid),
        .wb_rd_i(wb_rd), .flush_i(flush), .flush_n_i(flush_n), .occupancy_o(occ_z),
        .empty_o(empty_z), .full_o(full_z), .err_o(err_z));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_we = 1'b0; issue_rd = '0;
        wb_valid = 1'b0; wb_rd = '0; flush = 1'b0; flush_n = '0;
    endtask

    task automatic set_src(input logic v0, input logic [4:0] a0, input logic v1, input logic [4:0] a1);
        src_valid = {v1, v0};
        src_addr  = {a1, a0};
        #1;
    endtask

    task automatic issue(input logic we, input logic [4:0] rd);
        idle();
        issue_valid = 1'b1; issue_we = we; issue_rd = rd;
        tick();
        idle();
    endtask

    task automatic retire(input logic [4:0] rd);
        idle();
        wb_valid = 1'b1; wb_rd = rd;
        tick();
        idle();
    endtask

    task automatic do_reset();
        idle();
        rstn = 1'b0;
        #1;
        tick();
        rstn = 1'b1;
        #1;
    endtask

    initial begin
        logic [1:0] eh;
        logic       ef, es, ea, iv, iw, wv;
        logic [4:0] ir, a0, a1;
        logic       v0, v1;
        int         ph;

        idle();
        set_src(1'b1, 5'd5, 1'b0, 5'd0);
        do_reset();

        // reset state
        chk("rst_stall", stall, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_occ", occ, 0);
        chk("rst_err", err, 0);
        chk("rst_haz", haz, 0);

        // issue x5 then RAW on x5
        idle();
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd5;
        #1;
        chk("t1_accept", acc, 1);
        chk("t1_haz_same_cycle", haz, 0);
        tick();
        idle();
        set_src(1'b1, 5'd5, 1'b1, 5'd5);
        chk("t1_haz_both", haz, 2'b11);
        chk("t1_stall", stall, 1);
        chk("t1_occ", occ, 1);
        wb_valid = 1'b1; wb_rd = 5'd5;
        #1;
        chk("t1_haz_retiring_head", haz, 2'b11);
        tick();
        idle();
        #1;
        chk("t1_haz_cleared", haz, 0);
        chk("t1_empty", empty, 1);

        // x0 write: hazard only without hardwired zero
        issue(1'b1, 5'd0);
        set_src(1'b1, 5'd0, 1'b0, 5'd0);
        chk("t2_x0_zr1", haz, 0);
        chk("t2_x0_zr0", haz_z, 2'b01);
        chk("t2_stall_zr0", stall_z, 1);
        retire(5'd0);
        set_src(1'b0, 5'd0, 1'b0, 5'd0);

        // fill to DEPTH
        issue(1'b1, 5'd1);
        issue(1'b1, 5'd2);
        issue(1'b1, 5'd3);
        issue(1'b1, 5'd4);
        chk("t3_full", full, 1);
        chk("t3_stall_full", stall, 1);
        chk("t3_occ4", occ, 4);
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd9;
        wb_valid = 1'b1; wb_rd = 5'd1;
        #1;
        chk("t3_accept_full_wb", acc, 0);
        tick();
        idle();
        chk("t3_occ3", occ, 3);
        chk("t3_err", err, 0);
        retire(5'd2);
        retire(5'd3);
        retire(5'd4);
        chk("t3_drained", empty, 1);

        // retire + flush same cycle
        issue(1'b1, 5'd1);
        issue(1'b1, 5'd2);
        issue(1'b1, 5'd3);
        set_src(1'b1, 5'd3, 1'b0, 5'd0);
        wb_valid = 1'b1; wb_rd = 5'd1; flush = 1'b1; flush_n = 3'd2;
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd8;
        #1;
        chk("t4_accept_flush", acc, 0);
        chk("t4_haz_before", haz, 2'b01);
        tick();
        idle();
        #1;
        chk("t4_empty", empty, 1);
        chk("t4_occ", occ, 0);
        chk("t4_haz_after", haz, 0);
        chk("t4_err", err, 0);

        // flush count clamps, flush_n=0 is a no-op
        issue(1'b1, 5'd5);
        flush = 1'b1; flush_n = 3'd4;
        tick();
        idle();
        chk("t4_clamp_empty", empty, 1);
        chk("t4_clamp_err", err, 0);
        issue(1'b1, 5'd6);
        flush = 1'b1; flush_n = 3'd0;
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd7;
        #1;
        chk("t4_flush0_accept", acc, 0);
        tick();
        idle();
        chk("t4_flush0_occ", occ, 1);
        retire(5'd6);
        chk("t4_flush0_drain", empty, 1);

        // protocol errors and async reset
        retire(5'd0);
        chk("t5_err_empty", err, 1);
        chk("t5_occ_no_underflow", occ, 0);
        tick();
        chk("t5_err_sticky", err, 1);
        issue(1'b1, 5'd6);
        chk("t5_occ_pre_rst", occ, 1);
        rstn = 1'b0;
        #1;
        chk("t5_async_occ", occ, 0);
        chk("t5_async_err", err, 0);
        tick();
        rstn = 1'b1;
        #1;
        issue(1'b0, 5'd6);
        retire(5'd7);
        chk("t5_no_we_no_err", err, 0);
        issue(1'b1, 5'd6);
        retire(5'd7);
        chk("t5_rd_mismatch_err", err, 1);
        chk("t5_mismatch_popped", occ, 0);

        // randomised fill/drain against a reference queue
        do_reset();
        q.delete();
        for (int cyc = 0; cyc < 240; cyc++) begin
            ph = (cyc / 20) % 2;
            iv = (ph == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0);
            wv = (q.size() > 0) && ((ph == 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0));
            iw = 1'($urandom_range(0, 3) != 0);
            ir = 5'($urandom_range(0, 7));
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            a0 = 5'($urandom_range(0, 7));
            a1 = 5'($urandom_range(0, 7));
            idle();
            issue_valid = iv; issue_we = iw; issue_rd = ir;
            wb_valid = wv; wb_rd = wv ? q[0].rd : 5'd0;
            set_src(v0, a0, v1, a1);
            eh = '0;
            foreach (q[j]) begin
                if (v0 && q[j].we && q[j].rd == a0 && a0 != 5'd0) eh[0] = 1'b1;
                if (v1 && q[j].we && q[j].rd == a1 && a1 != 5'd0) eh[1] = 1'b1;
            end
            ef = (q.size() == 4);
            es = (|eh) | ef;
            ea = iv & ~es;
            chk("rnd_haz", haz, eh);
            chk("rnd_stall", stall, es);
            chk("rnd_accept", acc, ea);
            chk("rnd_occ", occ, q.size());
            tick();
            if (wv) void'(q.pop_front());
            if (ea) q.push_back('{we: iw, rd: ir});
        end
        idle();
        #1;
        chk("rnd_err", err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
